// File: rtl/class_distributor_if.sv
// class_distributor_if: transaction input, per-class FIFO write ports and status of the class distributor
interface class_distributor_if #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 8
);
  logic [3:0]       state;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             almost_full0, almost_full1, almost_full2, almost_full3;
  logic             ready_out;
  logic             push0, push1, push2, push3;
  logic [WIDTH-1:0] data_out0, data_out1, data_out2, data_out3;
  logic [CNT_W-1:0] count0, count1, count2, count3;
  logic             hold_active;
  modport master (
    output state, data_in, valid_in, almost_full0, almost_full1, almost_full2, almost_full3,
    input  ready_out, push0, push1, push2, push3, data_out0, data_out1, data_out2, data_out3,
           count0, count1, count2, count3, hold_active
  );
  modport slave (
    input  state, data_in, valid_in, almost_full0, almost_full1, almost_full2, almost_full3,
    output ready_out, push0, push1, push2, push3, data_out0, data_out1, data_out2, data_out3,
           count0, count1, count2, count3, hold_active
  );
endinterface

// File: rtl/class_distributor.sv
// class_distributor: steers a transaction stream into four class FIFOs, parking one word while its FIFO is almost full
module class_distributor #(
  parameter int WIDTH  = 12,
  parameter int CLS_HI = 11,
  parameter int CNT_W  = 8
) (
  input  logic clk,
  input  logic reset_L,
  class_distributor_if.slave bus
);
  localparam logic [3:0] INIT = 4'b0001;
  typedef enum logic {PASS, HOLD} fsm_e;
  fsm_e                  fsm_q, fsm_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic [1:0]            hcls_q, hcls_d;
  logic [3:0]            push_q, push_d;
  logic [3:0][WIDTH-1:0] dout_q, dout_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            af;
  logic [1:0]            cls;
  logic                  init;
  assign af   = {bus.almost_full3, bus.almost_full2, bus.almost_full1, bus.almost_full0};
  assign cls  = bus.data_in[CLS_HI -: 2];
  assign init = bus.state == INIT;
  always_comb begin
    fsm_d  = fsm_q;
    hold_d = hold_q;
    hcls_d = hcls_q;
    push_d = '0;
    dout_d = dout_q;
    if (init) begin
      fsm_d  = PASS;
      hold_d = '0;
      hcls_d = '0;
      dout_d = '0;
    end else if (fsm_q == PASS && bus.valid_in) begin
      if (af[cls]) begin
        fsm_d  = HOLD;
        hold_d = bus.data_in;
        hcls_d = cls;
      end else begin
        push_d[cls] = 1'b1;
        dout_d[cls] = bus.data_in;
      end
    end else if (fsm_q == HOLD && !af[hcls_q]) begin
      fsm_d          = PASS;
      push_d[hcls_q] = 1'b1;
      dout_d[hcls_q] = hold_q;
      hold_d         = '0;
      hcls_d         = '0;
    end
    for (int i = 0; i < 4; i++) cnt_d[i] = init ? '0 : cnt_q[i] + CNT_W'(push_d[i]);
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fsm_q  <= PASS;
      hold_q <= '0;
      hcls_q <= '0;
      push_q <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      hold_q <= hold_d;
      hcls_q <= hcls_d;
      push_q <= push_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end
  assign bus.ready_out   = fsm_q == PASS;
  assign bus.hold_active = fsm_q == HOLD;
  assign {bus.push3, bus.push2, bus.push1, bus.push0} = push_q;
  assign bus.data_out0 = dout_q[0];
  assign bus.data_out1 = dout_q[1];
  assign bus.data_out2 = dout_q[2];
  assign bus.data_out3 = dout_q[3];
  assign bus.count0    = cnt_q[0];
  assign bus.count1    = cnt_q[1];
  assign bus.count2    = cnt_q[2];
  assign bus.count3    = cnt_q[3];
endmodule

// File: doc/class_distributor.md
Name: class_distributor

Overview:
- Transmit-side counterpart of the four-class output selector.
- Takes a single 12-bit transaction stream and steers each word into one of four per-class FIFOs (class 0..3), chosen by the word's class field.
- Respects each FIFO's almost-full backpressure using a one-entry hold register, and throttles upstream with ready_out.
- Sits between the transaction source and the four class FIFOs.

Parameters:
WIDTH, 12, data word width
CLS_HI, 11, MSB index of the 2-bit class field inside the data word
CNT_W, 8, width of per-class push counters

Ports:
clk  input  1  system clock, all logic on posedge
reset_L  input  1  asynchronous active-low reset
state  input  4  global link state; 4'b0001 = INIT
data_in  input  WIDTH  incoming transaction word
valid_in  input  1  data_in valid
almost_full0..almost_full3  input  1 each  per-class FIFO almost-full
ready_out  output  1  block can accept a word this cycle
push0..push3  output  1 each  write strobe to class FIFO n
data_out0..data_out3  output  WIDTH each  write data to class FIFO n
count0..count3  output  CNT_W each  pushes issued to class n since reset/INIT
hold_active  output  1  a word is parked in the hold register

Behaviour:
- Destination class: d = data_in[CLS_HI:CLS_HI-1].
- Transfer rule: a word is accepted only on a posedge with valid_in=1 and ready_out=1. valid_in while ready_out=0 is ignored; upstream must keep the word.
- FSM, two states, PASS and HOLD. ready_out = (fsm==PASS), decoded directly from the state register. hold_active = (fsm==HOLD).
- PASS, word accepted, almost_full[d]=0: next cycle push_d=1 and data_out_d=data_in. Stay in PASS. Latency is 1 cycle, throughput 1 word/cycle.
- PASS, word accepted, almost_full[d]=1: capture the word and d into the hold register, go to HOLD. No push.
- HOLD: every cycle sample almost_full[hold_d].
  - While it is 1: stay in HOLD.
  - When it is 0: next cycle push_hold_d=1 and data_out_hold_d=hold word, go to PASS.
  - ready_out returns to 1 in the same cycle as that push. No new word is accepted during HOLD, including on the release edge.
- Push strobes:
  - At most one push_n is high per cycle.
  - A push_n is high for exactly one cycle per word.
  - push_n is registered and low whenever no push is issued that cycle.
- data_out_n is registered. It holds its last value when push_n=0.
- Counters: count_n increments by 1 on every cycle push_n=1. Wraps modulo 2^CNT_W with no saturation.
- state==INIT (4'b0001), synchronous, highest priority after reset:
  - fsm goes to PASS; the hold register is cleared and its word is dropped.
  - All push_n=0, all data_out_n=0, all count_n=0.
  - Words presented during INIT are discarded even though ready_out=1. ready_out stays 1 in INIT.
- Other state values have no effect on behaviour.
- reset_L=0, asynchronous, any cycle including mid-HOLD:
  - fsm=PASS, so ready_out=1 and hold_active=0.
  - push_n=0, data_out_n=0, count_n=0, hold register=0.
- Simultaneous events:
  - almost_full of a class other than d has no effect.
  - almost_full[d] rising in the cycle after the push is the FIFO's responsibility (almost-full margin ≥1).
  - INIT overrides a pending release from HOLD.

Test Plan:
- Reset, then valid_in=1 with data_in=12'h0A5 (class 0), 12'h4C3 (class 1), 12'h8F0 (class 2), 12'hC11 (class 3) on consecutive cycles, all almost_full=0 -> push0..push3 pulse on consecutive cycles, 1 cycle after each input. data_out values match. count0..3=1. ready_out stays 1.
- almost_full2=1, send 12'h8AB -> no push, hold_active=1, ready_out=0. Hold valid_in with 12'h123 for 5 cycles -> not accepted. Drop almost_full2 -> next cycle push2=1, data_out2=12'h8AB, ready_out=1. 12'h123 is then accepted and push0 fires 1 cycle later.
- While held on class 2, almost_full0/1/3 toggle -> no push on any class until almost_full2=0.
- Mid-HOLD: assert state=4'b0001 for 1 cycle -> hold dropped, ready_out=1, all counts=0, data_out_n=0. No push of the held word ever occurs.
- Push 256 class-1 words with CNT_W=8 -> count1 wraps to 0. Push one more -> count1=1.
- Assert reset_L=0 asynchronously between edges during HOLD with count3=7 -> outputs clear immediately with no clock edge: push_n=0, count3=0, hold_active=0, ready_out=1.
